// File: rtl/brick_mem_arbiter_pkg.sv
// Shared geometry macros, types and the arbitration helper for the brick-health RAM arbiter.
`ifndef BRICKX
`define BRICKX 40
`endif
`ifndef BRICKY
`define BRICKY 20
`endif
`ifndef BRICK_COLS
`define BRICK_COLS 16
`endif
`ifndef BRICK_ROWS
`define BRICK_ROWS 12
`endif
`ifndef BRICK_HEALTH_W
`define BRICK_HEALTH_W 2
`endif

package brick_mem_arbiter_pkg;
   localparam int NPORT    = 3;
   localparam int PIX_W    = 10;
   localparam int HEALTH_W = `BRICK_HEALTH_W;

   typedef logic [1:0]          port_t;
   typedef logic [PIX_W-1:0]    pix_t;
   typedef logic [HEALTH_W-1:0] health_t;

   // First requesting port at or after start, wrapping; only meaningful when req != 0.
   function automatic port_t pick_port(input logic [NPORT-1:0] req, input port_t start);
      port_t p;
      logic  found;
      int    idx;
      p     = start;
      found = 1'b0;
      for (int k = 0; k < NPORT; k++) begin
         idx = (int'(start) + k) % NPORT;
         if (!found && req[idx[1:0]]) begin
            found = 1'b1;
            p     = port_t'(idx);
         end
      end
      return p;
   endfunction
endpackage

// File: rtl/brick_addr_calc.sv
// Maps pixel coordinates to a brick RAM address and flags pixels outside the brick grid.
// Purely combinational.
module brick_addr_calc
   import brick_mem_arbiter_pkg::*;
#(
   parameter int BRICK_W = `BRICKX,
   parameter int BRICK_H = `BRICKY,
   parameter int COLS    = `BRICK_COLS,
   parameter int ROWS    = `BRICK_ROWS,
   parameter int ADDR_W  = 8
)(
   input  logic [PIX_W-1:0]  i_px,
   input  logic [PIX_W-1:0]  i_py,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_in_range
);
   pix_t w_col;
   pix_t w_row;

   assign w_col = i_px / PIX_W'(BRICK_W);
   assign w_row = i_py / PIX_W'(BRICK_H);

   // Computing at ADDR_W bits gives the wrap-around truncation directly.
   assign o_addr     = ADDR_W'(w_row) * ADDR_W'(COLS) + ADDR_W'(w_col);
   assign o_in_range = (w_col < PIX_W'(COLS)) && (w_row < PIX_W'(ROWS));
endmodule

// File: rtl/brick_mem_arbiter.sv
// Shares the single-port brick-health RAM between collision (0), loader (1) and drawer (2).
// Build option BRICK_ARB_RR_EN selects round-robin; otherwise fixed priority 0 > 1 > 2.
module brick_mem_arbiter
   import brick_mem_arbiter_pkg::*;
#(
   parameter int BRICK_W = `BRICKX,
   parameter int BRICK_H = `BRICKY,
   parameter int COLS    = `BRICK_COLS,
   parameter int ROWS    = `BRICK_ROWS,
   parameter int ADDR_W  = 8
)(
   input  logic                        clk,
   input  logic                        resetn,
   input  logic [NPORT-1:0]            req,
   input  logic [NPORT-1:0]            we,
   input  logic [NPORT*PIX_W-1:0]      px,
   input  logic [NPORT*PIX_W-1:0]      py,
   input  logic [NPORT*HEALTH_W-1:0]   wdata,
   output logic [NPORT-1:0]            gnt,
   output logic [NPORT-1:0]            done,
   output logic [HEALTH_W-1:0]         rdata,
   output logic                        busy,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic                        mem_wren,
   output logic [HEALTH_W-1:0]         mem_wdata,
   input  logic [HEALTH_W-1:0]         mem_q
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   port_t               w_start;
   port_t               w_pick;
   pix_t                w_px;
   pix_t                w_py;
   health_t             w_wdata;
   logic                w_we;
   logic [ADDR_W-1:0]   w_addr;
   logic                w_in_range;

   logic [NPORT-1:0]    r_gnt;
   logic [NPORT-1:0]    r_done;
   health_t             r_rdata;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic                r_mem_wren;
   health_t             r_mem_wdata;
   logic                r_we;
   logic                r_in_range;

`ifdef BRICK_ARB_RR_EN
   port_t r_rr_ptr;

   assign w_start = r_rr_ptr;

   always_ff @(posedge clk) begin
      if (!resetn)
         r_rr_ptr <= '0;
      else if (r_state == IDLE && |req)
         r_rr_ptr <= (w_pick == port_t'(NPORT-1)) ? '0 : w_pick + 2'd1;
   end
`else
   assign w_start = '0;
`endif

   assign w_pick = pick_port(req, w_start);

   always_comb begin
      w_px    = px[0 +: PIX_W];
      w_py    = py[0 +: PIX_W];
      w_wdata = wdata[0 +: HEALTH_W];
      w_we    = we[0];
      case (w_pick)
         2'd1: begin
            w_px    = px[PIX_W +: PIX_W];
            w_py    = py[PIX_W +: PIX_W];
            w_wdata = wdata[HEALTH_W +: HEALTH_W];
            w_we    = we[1];
         end
         2'd2: begin
            w_px    = px[2*PIX_W +: PIX_W];
            w_py    = py[2*PIX_W +: PIX_W];
            w_wdata = wdata[2*HEALTH_W +: HEALTH_W];
            w_we    = we[2];
         end
         default: ;
      endcase
   end

   brick_addr_calc #(
      .BRICK_W (BRICK_W),
      .BRICK_H (BRICK_H),
      .COLS    (COLS),
      .ROWS    (ROWS),
      .ADDR_W  (ADDR_W)
   ) u_addr_calc (
      .i_px       (w_px),
      .i_py       (w_py),
      .o_addr     (w_addr),
      .o_in_range (w_in_range)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (|req) w_state_nxt = ISSUE;
         ISSUE:   w_state_nxt = WAIT;
         WAIT:    w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   // mem_addr deliberately holds its last value between transactions.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_gnt       <= '0;
         r_done      <= '0;
         r_rdata     <= '0;
         r_mem_addr  <= '0;
         r_mem_wren  <= 1'b0;
         r_mem_wdata <= '0;
         r_we        <= 1'b0;
         r_in_range  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (|req) begin
                  r_gnt       <= NPORT'(1) << w_pick;
                  r_mem_addr  <= w_addr;
                  r_mem_wdata <= w_wdata;
                  r_mem_wren  <= w_we & w_in_range;
                  r_we        <= w_we;
                  r_in_range  <= w_in_range;
               end
            end
            ISSUE: r_mem_wren <= 1'b0;
            WAIT: begin
               if (!r_we)
                  r_rdata <= r_in_range ? mem_q : '0;
               r_done <= r_gnt;
            end
            DONE: begin
               r_done <= '0;
               r_gnt  <= '0;
            end
            default: ;
         endcase
      end
   end

   assign gnt       = r_gnt;
   assign done      = r_done;
   assign rdata     = r_rdata;
   assign busy      = (r_state != IDLE);
   assign mem_addr  = r_mem_addr;
   assign mem_wren  = r_mem_wren;
   assign mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_brick_mem_arbiter.sv
// Randomized bench for brick_mem_arbiter with a transaction-level reference model and RAM model.
module tb_brick_mem_arbiter;
   localparam int BW = 40;
   localparam int BH = 20;
   localparam int NC = 16;
   localparam int NR = 12;
   localparam int AW = 8;

   logic        clk = 1'b0;
   logic        resetn;
   logic [2:0]  req, we, gnt, done;
   logic [29:0] px, py;
   logic [5:0]  wdata;
   logic [1:0]  rdata, mem_wdata, mem_q;
   logic        busy, mem_wren;
   logic [7:0]  mem_addr;

   always #5 clk = ~clk;

   logic [2:0] t_req, t_we;
   logic [9:0] t_px [3];
   logic [9:0] t_py [3];
   logic [1:0] t_wd [3];

   assign req   = t_req;
   assign we    = t_we;
   assign px    = {t_px[2], t_px[1], t_px[0]};
   assign py    = {t_py[2], t_py[1], t_py[0]};
   assign wdata = {t_wd[2], t_wd[1], t_wd[0]};

   brick_mem_arbiter #(
      .BRICK_W (BW), .BRICK_H (BH), .COLS (NC), .ROWS (NR), .ADDR_W (AW)
   ) dut (
      .clk (clk), .resetn (resetn), .req (req), .we (we), .px (px), .py (py),
      .wdata (wdata), .gnt (gnt), .done (done), .rdata (rdata), .busy (busy),
      .mem_addr (mem_addr), .mem_wren (mem_wren), .mem_wdata (mem_wdata), .mem_q (mem_q)
   );

   // RAM: registered address, unregistered output, plus a bench-side load port.
   logic [1:0] ram [256];
   logic [7:0] ram_a;
   logic       ld_en;
   logic [7:0] ld_a;
   logic [1:0] ld_d;

   always @(posedge clk) begin
      if (ld_en)
         ram[ld_a] <= ld_d;
      else if (mem_wren)
         ram[mem_addr] <= mem_wdata;
      ram_a <= mem_addr;
   end
   assign mem_q = ram[ram_a];

   // Reference model state
   logic [1:0] sh [256];
   logic [1:0] m_rdata;
   int         ptr;
   int         last_w;
   int         n_chk = 0;
   int         n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int pick_model(input logic [2:0] r, input int start);
      int idx;
      for (int k = 0; k < 3; k++) begin
         idx = (start + k) % 3;
         if (r[idx[1:0]]) return idx;
      end
      return 0;
   endfunction

   task automatic ram_load(input int a, input logic [1:0] d);
      ld_en = 1'b1;
      ld_a  = a[7:0];
      ld_d  = d;
      sh[a] = d;
      @(posedge clk);
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   task automatic new_op(input int p);
      t_req[p] = 1'b1;
      t_we[p]  = 1'($urandom_range(0, 1));
      t_px[p]  = 10'($urandom_range(0, 700));
      t_py[p]  = 10'($urandom_range(0, 270));
      t_wd[p]  = 2'($urandom_range(0, 3));
   endtask

   // Called at a negedge with the DUT idle and t_req != 0; follows one full grant.
   task automatic serve(input string nm);
      int w, col, row, addr;
      bit inr, wr;
`ifdef BRICK_ARB_RR_EN
      w = pick_model(t_req, ptr);
`else
      w = pick_model(t_req, 0);
`endif
      col  = int'(t_px[w]) / BW;
      row  = int'(t_py[w]) / BH;
      inr  = (col < NC) && (row < NR);
      addr = (row * NC + col) % 256;
      wr   = t_we[w];

      @(posedge clk); @(negedge clk);
      chk({nm, "_issue_gnt"},   gnt, 32'(1 << w));
      chk({nm, "_issue_busy"},  busy, 1);
      chk({nm, "_issue_addr"},  mem_addr, addr);
      chk({nm, "_issue_wren"},  mem_wren, wr && inr);
      chk({nm, "_issue_wdata"}, mem_wdata, t_wd[w]);
      chk({nm, "_issue_done"},  done, 0);

      @(posedge clk); @(negedge clk);
      chk({nm, "_wait_wren"}, mem_wren, 0);
      chk({nm, "_wait_done"}, done, 0);
      chk({nm, "_wait_gnt"},  gnt, 32'(1 << w));

      @(posedge clk); @(negedge clk);
      if (!wr) m_rdata = inr ? sh[addr] : 2'd0;
      if (wr && inr) sh[addr] = t_wd[w];
      chk({nm, "_done"},       done, 32'(1 << w));
      chk({nm, "_done_rdata"}, rdata, m_rdata);
      chk({nm, "_done_gnt"},   gnt, 32'(1 << w));
      ptr    = (w + 1) % 3;
      last_w = w;

      @(posedge clk); @(negedge clk);
      chk({nm, "_idle_done"}, done, 0);
      chk({nm, "_idle_gnt"},  gnt, 0);
      chk({nm, "_idle_busy"}, busy, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int a;
      logic [1:0] v;
      resetn  = 1'b0;
      t_req   = '0;
      t_we    = '0;
      ld_en   = 1'b0;
      ld_a    = '0;
      ld_d    = '0;
      m_rdata = '0;
      ptr     = 0;
      last_w  = -1;
      for (int p = 0; p < 3; p++) begin
         t_px[p] = '0; t_py[p] = '0; t_wd[p] = '0;
      end

      @(negedge clk);
      for (int i = 0; i < 256; i++) ram_load(i, 2'($urandom_range(0, 3)));

      chk("rst_gnt", gnt, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wren", mem_wren, 0);
      chk("rst_wdata", mem_wdata, 0);
      resetn = 1'b1;

      // Port 0 read at (85,45) -> brick 34
      ram_load(34, 2'd3);
      t_req = 3'b001; t_we = 3'b000; t_px[0] = 10'd85; t_py[0] = 10'd45;
      serve("t1");
      chk("t1_rdata_lit", rdata, 3);
      t_req = '0;

      // All three ports request together
      for (int p = 0; p < 3; p++) begin
         t_we[p] = 1'b0;
         t_px[p] = 10'($urandom_range(0, 639));
         t_py[p] = 10'($urandom_range(0, 239));
      end
      t_req = 3'b111;
      for (int k = 0; k < 3; k++) begin
         serve("t2");
         t_req[last_w] = 1'b0;
      end

      // Port 1 write of 2 at the origin, then read it back
      t_req = 3'b010; t_we = 3'b010; t_px[1] = 0; t_py[1] = 0; t_wd[1] = 2'd2;
      serve("t3w");
      t_req = 3'b001; t_we = 3'b000; t_px[0] = 0; t_py[0] = 0;
      serve("t3r");
      chk("t3_readback", rdata, 2);
      t_req = '0;

      // Off-grid column 17: read returns 0, write must not land anywhere
      ram_load(49, 2'd3);
      t_req = 3'b100; t_we = 3'b000; t_px[2] = 10'd700; t_py[2] = 10'd50;
      serve("t4r");
      chk("t4_rdata_zero", rdata, 0);
      t_we = 3'b100; t_wd[2] = 2'd1;
      serve("t4w");
      t_req = 3'b001; t_we = 3'b000; t_px[0] = 10'd40; t_py[0] = 10'd60;
      serve("t4chk");
      chk("t4_brick49_intact", rdata, 3);
      t_req = '0;

      // Reset while in WAIT: no done pulse afterwards
      t_req = 3'b001; t_we = 3'b000; t_px[0] = 10'd200; t_py[0] = 10'd100;
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      resetn = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("t5_gnt", gnt, 0);
      chk("t5_done", done, 0);
      chk("t5_busy", busy, 0);
      chk("t5_rdata", rdata, 0);
      resetn = 1'b1; t_req = '0; m_rdata = '0; ptr = 0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); @(negedge clk);
         chk("t5_no_done", done, 0);
      end

      // Reset asserted during ISSUE of a write: the write still commits
      a = 5 * NC + 7;
      v = ~sh[a];
      t_req = 3'b010; t_we = 3'b010; t_px[1] = 10'(7 * BW + 3); t_py[1] = 10'(5 * BH + 1); t_wd[1] = v;
      @(posedge clk); @(negedge clk);
      resetn = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("t5b_busy", busy, 0);
      resetn = 1'b1; t_req = '0; t_we = '0; m_rdata = '0; ptr = 0;
      sh[a] = v;
      t_req = 3'b001; t_px[0] = 10'(7 * BW); t_py[0] = 10'(5 * BH);
      serve("t5b");
      chk("t5b_commit", rdata, 32'(v));
      t_req = '0;

      // Ports 0 and 2 request continuously
      for (int p = 0; p < 3; p++) begin
         t_px[p] = 10'($urandom_range(0, 639));
         t_py[p] = 10'($urandom_range(0, 239));
      end
      t_we = '0;
      t_req = 3'b101;
      for (int k = 0; k < 4; k++) begin
         serve("t6");
`ifdef BRICK_ARB_RR_EN
         chk("t6_winner", last_w, (k % 2 == 0) ? 0 : 2);
`else
         chk("t6_winner", last_w, 0);
`endif
         t_px[last_w] = 10'($urandom_range(0, 639));
      end
      t_req = '0;

      // Randomized traffic
      last_w = -1;
      for (int r = 0; r < 200; r++) begin
         for (int p = 0; p < 3; p++) begin
            if (p == last_w) begin
               if ($urandom_range(0, 1) == 1) new_op(p);
               else t_req[p] = 1'b0;
            end else if (!t_req[p] && $urandom_range(0, 2) == 0) begin
               new_op(p);
            end
         end
         if (t_req != 3'b000) begin
            serve("rnd");
         end else begin
            last_w = -1;
            @(posedge clk); @(negedge clk);
            chk("rnd_idle_busy", busy, 0);
            chk("rnd_idle_gnt", gnt, 0);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
